// File: rtl/cpu_pkg.sv
// Shared decode constants, field positions and the ID/EX payload type.
package cpu_pkg;

   localparam int unsigned ID_DAT_WIDTH = 32;
   localparam int unsigned ID_ADD_WIDTH = 30;
   localparam int unsigned ID_REG_AW    = 5;

   localparam int unsigned OP_W     = 6;
   localparam int unsigned ALU_OP_W = 3;
   localparam int unsigned IMM_W    = 16;
   localparam int unsigned MEM_OP_W = 2;

   // Instruction field bit ranges
   localparam int unsigned OP_MSB  = 31;
   localparam int unsigned OP_LSB  = 26;
   localparam int unsigned RA_MSB  = 25;
   localparam int unsigned RA_LSB  = 21;
   localparam int unsigned RB_MSB  = 20;
   localparam int unsigned RB_LSB  = 16;
   localparam int unsigned RC_MSB  = 15;
   localparam int unsigned RC_LSB  = 11;
   localparam int unsigned IMM_MSB = 15;
   localparam int unsigned IMM_LSB = 0;

   // Opcode map; 0x00-0x07 are R-ALU, 0x08-0x0F are I-ALU
   localparam logic [OP_W-1:0] OP_ALU_R_MAX = 6'h07;
   localparam logic [OP_W-1:0] OP_ALU_I_MAX = 6'h0F;
   localparam logic [OP_W-1:0] OP_BE        = 6'h10;
   localparam logic [OP_W-1:0] OP_BNE       = 6'h11;
   localparam logic [OP_W-1:0] OP_JMP       = 6'h12;
   localparam logic [OP_W-1:0] OP_CALL      = 6'h13;
   localparam logic [OP_W-1:0] OP_LDW       = 6'h14;
   localparam logic [OP_W-1:0] OP_STW       = 6'h15;

   // ADD with a zero second operand doubles as "pass"
   localparam logic [ALU_OP_W-1:0]  ALU_ADD  = 3'd0;
   localparam logic [ID_REG_AW-1:0] LINK_REG = 5'd31;

   typedef enum logic [MEM_OP_W-1:0] {
      MEM_NONE  = 2'd0,
      MEM_LOAD  = 2'd1,
      MEM_STORE = 2'd2
   } mem_op_e;

   typedef struct packed {
      logic                    en;
      logic [ID_ADD_WIDTH-1:0] pc;
      logic [ALU_OP_W-1:0]     alu_op;
      logic [ID_DAT_WIDTH-1:0] alu_in_0;
      logic [ID_DAT_WIDTH-1:0] alu_in_1;
      mem_op_e                 mem_op;
      logic [ID_DAT_WIDTH-1:0] mem_wr_data;
      logic [ID_REG_AW-1:0]    dst_addr;
      logic                    gpr_we;
      logic                    illegal;
   } id_ex_t;

   localparam id_ex_t ID_EX_BUBBLE = '0;

   // Sign-extend the 16-bit immediate to the datapath width
   function automatic logic [ID_DAT_WIDTH-1:0] sext_imm(input logic [IMM_W-1:0] imm);
      return {{(ID_DAT_WIDTH - IMM_W){imm[IMM_W-1]}}, imm};
   endfunction

endpackage

// File: rtl/id_decoder.sv
// Combinational decode: operand selection, branch resolution and hazard detection.
// ID_FWD_EN: when defined, EX/MEM results are forwarded to the operands;
// otherwise operands come from the GPR file and any pending write stalls.
module id_decoder
   import cpu_pkg::*;
(
   input  logic [ID_ADD_WIDTH-1:0] if_pc_i,
   input  logic [ID_DAT_WIDTH-1:0] if_instru_i,
   input  logic                    if_en_i,
   output logic [ID_REG_AW-1:0]    gpr_rd_addr_0_o,
   output logic [ID_REG_AW-1:0]    gpr_rd_addr_1_o,
   input  logic [ID_DAT_WIDTH-1:0] gpr_rd_data_0_i,
   input  logic [ID_DAT_WIDTH-1:0] gpr_rd_data_1_i,
   input  logic                    ex_en_i,
   input  logic                    ex_gpr_we_i,
   input  logic                    ex_is_load_i,
   input  logic [ID_REG_AW-1:0]    ex_dst_addr_i,
   input  logic [ID_DAT_WIDTH-1:0] ex_fwd_data_i,
   input  logic                    mem_en_i,
   input  logic                    mem_gpr_we_i,
   input  logic [ID_REG_AW-1:0]    mem_dst_addr_i,
   input  logic [ID_DAT_WIDTH-1:0] mem_fwd_data_i,
   output id_ex_t                  dec_o,
   output logic                    br_taken_o,
   output logic [ID_ADD_WIDTH-1:0] br_addr_o,
   output logic                    ld_hazard_o
);

   logic [OP_W-1:0]         op;
   logic [ID_REG_AW-1:0]    ra;
   logic [ID_REG_AW-1:0]    rb;
   logic [ID_REG_AW-1:0]    rc;
   logic [ID_DAT_WIDTH-1:0] simm;
   logic [ID_DAT_WIDTH-1:0] opnd_a;
   logic [ID_DAT_WIDTH-1:0] opnd_b;
   logic [ID_ADD_WIDTH-1:0] rel_addr;
   logic [ID_ADD_WIDTH-1:0] link_pc;
   logic                    br_cond;

   assign op   = if_instru_i[OP_MSB:OP_LSB];
   assign ra   = if_instru_i[RA_MSB:RA_LSB];
   assign rb   = if_instru_i[RB_MSB:RB_LSB];
   assign rc   = if_instru_i[RC_MSB:RC_LSB];
   assign simm = sext_imm(if_instru_i[IMM_MSB:IMM_LSB]);

   assign gpr_rd_addr_0_o = ra;
   assign gpr_rd_addr_1_o = rb;

   // PC-relative target wraps modulo 2^30; link address skips the delay slot
   assign rel_addr = ID_ADD_WIDTH'(if_pc_i + ID_ADD_WIDTH'(1) + simm[ID_ADD_WIDTH-1:0]);
   assign link_pc  = ID_ADD_WIDTH'(if_pc_i + ID_ADD_WIDTH'(2));

`ifdef ID_FWD_EN
   logic ex_fwd_ok;
   logic mem_fwd_ok;

   // Loads in EX have no data yet, so they never forward
   assign ex_fwd_ok  = ex_en_i & ex_gpr_we_i & ~ex_is_load_i;
   assign mem_fwd_ok = mem_en_i & mem_gpr_we_i;

   // Operand select: EX result beats MEM result beats GPR file
   always_comb begin
      opnd_a = gpr_rd_data_0_i;
      opnd_b = gpr_rd_data_1_i;
      if (ex_fwd_ok && (ex_dst_addr_i == ra)) begin
         opnd_a = ex_fwd_data_i;
      end else if (mem_fwd_ok && (mem_dst_addr_i == ra)) begin
         opnd_a = mem_fwd_data_i;
      end
      if (ex_fwd_ok && (ex_dst_addr_i == rb)) begin
         opnd_b = ex_fwd_data_i;
      end else if (mem_fwd_ok && (mem_dst_addr_i == rb)) begin
         opnd_b = mem_fwd_data_i;
      end
   end

   assign ld_hazard_o = if_en_i & ex_en_i & ex_is_load_i & ex_gpr_we_i &
                        ((ex_dst_addr_i == ra) | (ex_dst_addr_i == rb));
`else
   logic ex_match;
   logic mem_match;
   logic unused_fwd;

   assign opnd_a = gpr_rd_data_0_i;
   assign opnd_b = gpr_rd_data_1_i;

   // Without forwarding, any in-flight write to a source must drain first
   assign ex_match  = ex_en_i & ex_gpr_we_i &
                      ((ex_dst_addr_i == ra) | (ex_dst_addr_i == rb));
   assign mem_match = mem_en_i & mem_gpr_we_i &
                      ((mem_dst_addr_i == ra) | (mem_dst_addr_i == rb));
   assign ld_hazard_o = if_en_i & (ex_match | mem_match);

   assign unused_fwd = ^{ex_is_load_i, ex_fwd_data_i, mem_fwd_data_i};
`endif

   // Opcode decode into the ID/EX payload plus branch condition/target
   always_comb begin
      dec_o        = ID_EX_BUBBLE;
      dec_o.en     = 1'b1;
      dec_o.pc     = if_pc_i;
      br_cond      = 1'b0;
      br_addr_o    = '0;
      if (op <= OP_ALU_R_MAX) begin
         dec_o.alu_op   = op[ALU_OP_W-1:0];
         dec_o.alu_in_0 = opnd_a;
         dec_o.alu_in_1 = opnd_b;
         dec_o.dst_addr = rc;
         dec_o.gpr_we   = 1'b1;
      end else if (op <= OP_ALU_I_MAX) begin
         dec_o.alu_op   = op[ALU_OP_W-1:0];
         dec_o.alu_in_0 = opnd_a;
         dec_o.alu_in_1 = simm;
         dec_o.dst_addr = rb;
         dec_o.gpr_we   = 1'b1;
      end else begin
         case (op)
            OP_BE: begin
               br_cond   = (opnd_a == opnd_b);
               br_addr_o = rel_addr;
            end
            OP_BNE: begin
               br_cond   = (opnd_a != opnd_b);
               br_addr_o = rel_addr;
            end
            OP_JMP: begin
               br_cond   = 1'b1;
               br_addr_o = opnd_a[ID_DAT_WIDTH-1:2];
            end
            OP_CALL: begin
               br_cond        = 1'b1;
               br_addr_o      = opnd_a[ID_DAT_WIDTH-1:2];
               dec_o.alu_op   = ALU_ADD;
               dec_o.alu_in_0 = {link_pc, 2'b00};
               dec_o.dst_addr = LINK_REG;
               dec_o.gpr_we   = 1'b1;
            end
            OP_LDW: begin
               dec_o.alu_op   = ALU_ADD;
               dec_o.alu_in_0 = opnd_a;
               dec_o.alu_in_1 = simm;
               dec_o.mem_op   = MEM_LOAD;
               dec_o.dst_addr = rb;
               dec_o.gpr_we   = 1'b1;
            end
            OP_STW: begin
               dec_o.alu_op      = ALU_ADD;
               dec_o.alu_in_0    = opnd_a;
               dec_o.alu_in_1    = simm;
               dec_o.mem_op      = MEM_STORE;
               dec_o.mem_wr_data = opnd_b;
            end
            default: begin
               dec_o.illegal = 1'b1;
            end
         endcase
      end
   end

   // A stalled or empty slot must not redirect fetch
   assign br_taken_o = br_cond & if_en_i & ~ld_hazard_o;

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: decoder plus the ID/EX pipeline register.
// ID_FWD_EN selects EX/MEM operand forwarding (default build: no forwarding).
module id_stage
   import cpu_pkg::*;
(
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [ID_ADD_WIDTH-1:0] if_pc_i,
   input  logic [ID_DAT_WIDTH-1:0] if_instru_i,
   input  logic                    if_en_i,
   input  logic                    stall_i,
   input  logic                    flush_i,
   output logic [ID_REG_AW-1:0]    gpr_rd_addr_0_o,
   output logic [ID_REG_AW-1:0]    gpr_rd_addr_1_o,
   input  logic [ID_DAT_WIDTH-1:0] gpr_rd_data_0_i,
   input  logic [ID_DAT_WIDTH-1:0] gpr_rd_data_1_i,
   input  logic                    ex_en_i,
   input  logic                    ex_gpr_we_i,
   input  logic                    ex_is_load_i,
   input  logic [ID_REG_AW-1:0]    ex_dst_addr_i,
   input  logic [ID_DAT_WIDTH-1:0] ex_fwd_data_i,
   input  logic                    mem_en_i,
   input  logic                    mem_gpr_we_i,
   input  logic [ID_REG_AW-1:0]    mem_dst_addr_i,
   input  logic [ID_DAT_WIDTH-1:0] mem_fwd_data_i,
   output logic                    br_taken_o,
   output logic [ID_ADD_WIDTH-1:0] br_addr_o,
   output logic                    ld_hazard_o,
   output logic [ID_ADD_WIDTH-1:0] id_pc_o,
   output logic                    id_en_o,
   output logic [ALU_OP_W-1:0]     id_alu_op_o,
   output logic [ID_DAT_WIDTH-1:0] id_alu_in_0_o,
   output logic [ID_DAT_WIDTH-1:0] id_alu_in_1_o,
   output logic [MEM_OP_W-1:0]     id_mem_op_o,
   output logic [ID_DAT_WIDTH-1:0] id_mem_wr_data_o,
   output logic [ID_REG_AW-1:0]    id_dst_addr_o,
   output logic                    id_gpr_we_o,
   output logic                    id_illegal_o
);

   id_ex_t dec;
   id_ex_t id_ex_d;
   id_ex_t id_ex_q;
   logic   ld_hazard;

   id_decoder u_decoder (
      .if_pc_i         (if_pc_i),
      .if_instru_i     (if_instru_i),
      .if_en_i         (if_en_i),
      .gpr_rd_addr_0_o (gpr_rd_addr_0_o),
      .gpr_rd_addr_1_o (gpr_rd_addr_1_o),
      .gpr_rd_data_0_i (gpr_rd_data_0_i),
      .gpr_rd_data_1_i (gpr_rd_data_1_i),
      .ex_en_i         (ex_en_i),
      .ex_gpr_we_i     (ex_gpr_we_i),
      .ex_is_load_i    (ex_is_load_i),
      .ex_dst_addr_i   (ex_dst_addr_i),
      .ex_fwd_data_i   (ex_fwd_data_i),
      .mem_en_i        (mem_en_i),
      .mem_gpr_we_i    (mem_gpr_we_i),
      .mem_dst_addr_i  (mem_dst_addr_i),
      .mem_fwd_data_i  (mem_fwd_data_i),
      .dec_o           (dec),
      .br_taken_o      (br_taken_o),
      .br_addr_o       (br_addr_o),
      .ld_hazard_o     (ld_hazard)
   );

   assign ld_hazard_o = ld_hazard;

   // ID/EX update priority: flush, stall (hold), hazard/empty bubble, issue
   always_comb begin
      id_ex_d = id_ex_q;
      if (flush_i) begin
         id_ex_d = ID_EX_BUBBLE;
      end else if (stall_i) begin
         id_ex_d = id_ex_q;
      end else if (ld_hazard || !if_en_i) begin
         id_ex_d = ID_EX_BUBBLE;
      end else begin
         id_ex_d = dec;
      end
   end

   // ID/EX pipeline register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         id_ex_q <= ID_EX_BUBBLE;
      end else begin
         id_ex_q <= id_ex_d;
      end
   end

   assign id_pc_o          = id_ex_q.pc;
   assign id_en_o          = id_ex_q.en;
   assign id_alu_op_o      = id_ex_q.alu_op;
   assign id_alu_in_0_o    = id_ex_q.alu_in_0;
   assign id_alu_in_1_o    = id_ex_q.alu_in_1;
   assign id_mem_op_o      = MEM_OP_W'(id_ex_q.mem_op);
   assign id_mem_wr_data_o = id_ex_q.mem_wr_data;
   assign id_dst_addr_o    = id_ex_q.dst_addr;
   assign id_gpr_we_o      = id_ex_q.gpr_we;
   assign id_illegal_o     = id_ex_q.illegal;

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction decode stage; sits directly downstream of the fetch stage and consumes its if_pc/if_instru/if_en outputs.
- Decodes the 32-bit instruction and reads two GPR operands, with forwarding from the EX and MEM stages.
- Resolves branches and jumps, driving br_taken/br_addr back to fetch, and detects load-use hazards.
- Registers the decoded operation into the ID/EX pipeline register under stall/flush control.

Parameters:
- ID_DAT_WIDTH, 32, data/instruction width.
- ID_ADD_WIDTH, 30, word-address (PC) width.
- ID_REG_AW, 5, GPR index width (32 GPRs).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- if_pc_i  in  30  PC of the fetched instruction.
- if_instru_i  in  32  fetched instruction.
- if_en_i  in  1  fetch data valid.
- stall_i  in  1  hold the ID/EX register.
- flush_i  in  1  squash the ID/EX register.
- gpr_rd_addr_0_o / gpr_rd_addr_1_o  out  5  GPR read indices (ra, rb).
- gpr_rd_data_0_i / gpr_rd_data_1_i  in  32  combinational GPR read data.
- ex_en_i, ex_gpr_we_i, ex_is_load_i  in  1  EX-stage valid, GPR write enable, and load flag.
- ex_dst_addr_i  in  5  EX-stage destination; ex_fwd_data_i  in  32  EX-stage result.
- mem_en_i, mem_gpr_we_i  in  1  MEM-stage valid and GPR write enable.
- mem_dst_addr_i  in  5  MEM-stage destination; mem_fwd_data_i  in  32  MEM-stage result.
- br_taken_o  out  1  branch/jump taken (combinational).
- br_addr_o  out  30  target word address (combinational).
- ld_hazard_o  out  1  load-use hazard request to the pipeline controller (combinational).
- id_pc_o  out  30; id_en_o  out  1.
- id_alu_op_o  out  3; id_alu_in_0_o / id_alu_in_1_o  out  32.
- id_mem_op_o  out  2 (0 none, 1 load, 2 store); id_mem_wr_data_o  out  32.
- id_dst_addr_o  out  5; id_gpr_we_o  out  1; id_illegal_o  out  1.

Behaviour:
- Instruction fields: op[31:26], ra[25:21], rb[20:16], rc[15:11], imm[15:0]; simm = sign-extended imm.
- Opcode 0x00-0x07, R-ALU: alu_op=op[2:0], in0=A, in1=B, dst=rc, we=1.
- Opcode 0x08-0x0F, I-ALU: alu_op=op[2:0], in0=A, in1=simm, dst=rb, we=1.
- Opcode 0x10 BE / 0x11 BNE: taken if A==B / A!=B; target = pc+1+simm[29:0], modulo 2^30 (wraps). we=0.
- Opcode 0x12 JMP: target = A[31:2], always taken.
- Opcode 0x13 CALL: as JMP, plus alu_op=0 (pass), in0={pc+2,2'b00}, dst=31, we=1.
- Opcode 0x14 LDW: alu_op=ADD(0), in0=A, in1=simm, mem_op=1, dst=rb, we=1.
- Opcode 0x15 STW: as LDW, but mem_op=2, wr_data=B, we=0.
- Any other opcode: illegal=1, we=0, mem_op=0, not taken.
- Exactly one architectural delay slot follows every branch/jump; ID never flushes fetch itself.
- Operand A (index ra) and B (index rb) are each resolved by priority: EX forward (ex_en & ex_gpr_we & dst match & !ex_is_load), then MEM forward (mem_en & mem_gpr_we & dst match), then GPR read data.
- R0 is not special.
- ld_hazard_o = if_en_i & ex_en_i & ex_is_load_i & ex_gpr_we_i & (ex_dst==ra | ex_dst==rb).
- br_taken_o is qualified by if_en_i & !ld_hazard_o.
- ID/EX register update, evaluated each rising edge in priority order:
  1. rst_i: all outputs 0, asynchronously.
  2. flush_i: load a bubble (en, we, mem_op, illegal = 0; other fields don't-care, driven 0). Flush wins over stall.
  3. stall_i: hold all fields.
  4. ld_hazard_o or !if_en_i: load a bubble.
  5. Otherwise: load the decoded fields, id_pc_o=if_pc_i, id_en_o=1.
- Latency: one cycle from if_* to id_*.
- Reset deasserted mid-stream: the first valid output appears the cycle after the first accepted if_en_i.

Optional Feature:
- ID_FWD_EN defined: forwarding paths exactly as above.
- ID_FWD_EN undefined: no forwarding; operands come from GPR only.
- Without it, ld_hazard_o also asserts for any if_en_i instruction whose ra/rb matches a valid, GPR-writing EX or MEM destination, regardless of load.

Decomposition:
- cpu_pkg holds the opcode localparams (OP_BE=6'h10 ... OP_STW=6'h15), the mem_op enum (MEM_NONE/LOAD/STORE), the ALU_ADD constant, and the field bit-range constants.
- One sub-module, id_decoder: combinational decode, operand selection, branch resolution, hazard detection.
- id_stage holds the ID/EX register and its priority logic.

Test Plan:
- Reset and ADDUI: rst_i pulse -> all outputs 0. Then instru={6'h09,ra=1,rb=2,imm=16'hFFFF}, gpr1=5 -> next cycle id_alu_in_0_o=5, id_alu_in_1_o=32'hFFFFFFFF, id_dst_addr_o=2, id_gpr_we_o=1, id_en_o=1.
- BE taken with wrap: pc=30'h3FFFFFFF, A==B, imm=16'h0002 -> br_taken_o=1, br_addr_o=30'h00000002 in the same cycle.
- BNE not taken: A==B -> br_taken_o=0.
- Forward priority: ex_dst=3, ex data=0xAA; mem_dst=3, mem data=0xBB; instru reads ra=3 -> in0=0xAA. With ex_en_i=0 -> in0=0xBB.
- Load-use: ex_is_load_i=1, ex_dst=4; instru with rb=4 -> ld_hazard_o=1, next id_en_o=0, br_taken_o suppressed. Next cycle without hazard -> decoded instruction issues.
- Stall/flush: stall_i held 3 cycles -> id_* unchanged. stall_i and flush_i together -> bubble. Opcode 6'h3F -> id_illegal_o=1, id_gpr_we_o=0.
